// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
// Pipelined carry-lookahead adder/subtractor for the datapath ALU.
// The operands are cut into SEG_W-bit segments; stage k resolves segment k with
// 4-bit group lookahead and hands its carry to stage k+1 through a register.
// An entry rank registers the operands, so a beat accepted on edge E0 appears
// on the outputs after edge E0+NSTG. All ranks advance together; a full output
// that is not taken stalls the whole pipe.
//
// Ports
//   clk                       rising-edge clock
//   clr                       asynchronous active-high reset
//   i_valid / o_ready         operand beat handshake (o_ready = !o_valid | i_ready)
//   i_a, i_b [WIDTH]          operands
//   i_sub                     0: A+B+i_cin, 1: A+~B+1
//   i_cin                     carry in, add mode only
//   o_valid / i_ready         result beat handshake
//   o_result [WIDTH]          sum / difference
//   o_cout                    carry out of MSB (subtract: 1 = no borrow)
//   o_ovf                     signed overflow
//   o_zero                    o_result == 0
//   o_neg                     o_result[WIDTH-1]
// -----------------------------------------------------------------------------
module cla_pipe_addsub #(
   parameter int WIDTH = 32,
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_sub,
   input  logic             i_cin,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_neg
);

   localparam int NSTG = WIDTH / SEG_W;
   localparam int NGRP = SEG_W / 4;

   if ((SEG_W < 4) || ((SEG_W % 4) != 0) || (WIDTH < SEG_W) || ((WIDTH % SEG_W) != 0)) begin : g_param_check
      $error("cla_pipe_addsub: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
   end

   // Carries c[0..SEG_W] of one segment. Each 4-bit group is fully expanded
   // from its own G/P terms and the group carry-in; groups chain serially.
   function automatic logic [SEG_W:0] seg_carries(input logic [SEG_W-1:0] a,
                                                  input logic [SEG_W-1:0] b,
                                                  input logic             cin);
      logic [SEG_W:0] c;
      logic [3:0]     g;
      logic [3:0]     p;
      c    = {(SEG_W+1){1'b0}};
      c[0] = cin;
      for (int grp = 0; grp < NGRP; grp++) begin
         g = a[grp*4 +: 4] & b[grp*4 +: 4];
         p = a[grp*4 +: 4] ^ b[grp*4 +: 4];
         c[grp*4+1] = g[0] | (p[0] & c[grp*4]);
         c[grp*4+2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[grp*4]);
         c[grp*4+3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[grp*4]);
         c[grp*4+4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[grp*4]);
      end
      return c;
   endfunction

   // Rank r holds a beat that has had r segments resolved. x carries the
   // mixed operand/result word: the next operand segment is always in the low
   // SEG_W bits and each resolved segment is inserted at the top, so after
   // NSTG stages x is exactly the result in natural order. b shifts the same
   // way, so every stage reads only the low segment.
   logic [NSTG:0]    v_q, v_d;
   logic [NSTG:0]    c_q, c_d;
   logic [WIDTH-1:0] x_q [0:NSTG];
   logic [WIDTH-1:0] x_d [0:NSTG];
   logic [WIDTH-1:0] b_q [0:NSTG-1];
   logic [WIDTH-1:0] b_d [0:NSTG-1];
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;
   logic [SEG_W:0]   cy  [0:NSTG-1];
   logic [SEG_W-1:0] sum [0:NSTG-1];
   logic             adv;

   assign adv     = ~v_q[NSTG] | i_ready;
   assign o_ready = adv;

   // Entry rank load, per-stage segment resolve and final flag generation.
   always_comb begin
      v_d = {(NSTG+1){1'b0}};
      c_d = {(NSTG+1){1'b0}};
      v_d[0] = i_valid;
      // Idle cycles load zeros so unknown operands never reach the outputs.
      if (i_valid) begin
         x_d[0] = i_a;
         b_d[0] = i_sub ? ~i_b : i_b;
         c_d[0] = i_sub ? 1'b1 : i_cin;
      end else begin
         x_d[0] = {WIDTH{1'b0}};
         b_d[0] = {WIDTH{1'b0}};
         c_d[0] = 1'b0;
      end
      for (int k = 0; k < NSTG; k++) begin
         cy[k]  = seg_carries(x_q[k][SEG_W-1:0], b_q[k][SEG_W-1:0], c_q[k]);
         sum[k] = x_q[k][SEG_W-1:0] ^ b_q[k][SEG_W-1:0] ^ cy[k][SEG_W-1:0];
         x_d[k+1] = x_q[k] >> SEG_W;
         x_d[k+1][WIDTH-1 -: SEG_W] = sum[k];
         c_d[k+1] = cy[k][SEG_W];
         v_d[k+1] = v_q[k];
      end
      for (int k = 0; k < NSTG - 1; k++) begin
         b_d[k+1] = b_q[k] >> SEG_W;
      end
      // Carry into the MSB is bit SEG_W-1 of the last segment's carry chain.
      ovf_d  = cy[NSTG-1][SEG_W] ^ cy[NSTG-1][SEG_W-1];
      zero_d = (x_d[NSTG] == {WIDTH{1'b0}});
      neg_d  = x_d[NSTG][WIDTH-1];
   end

   // Pipeline ranks: cleared by clr, all shift on adv, all hold otherwise.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         v_q    <= {(NSTG+1){1'b0}};
         c_q    <= {(NSTG+1){1'b0}};
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         for (int k = 0; k <= NSTG; k++) begin
            x_q[k] <= {WIDTH{1'b0}};
         end
         for (int k = 0; k < NSTG; k++) begin
            b_q[k] <= {WIDTH{1'b0}};
         end
      end else if (adv) begin
         v_q    <= v_d;
         c_q    <= c_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
         neg_q  <= neg_d;
         for (int k = 0; k <= NSTG; k++) begin
            x_q[k] <= x_d[k];
         end
         for (int k = 0; k < NSTG; k++) begin
            b_q[k] <= b_d[k];
         end
      end
   end

   assign o_valid  = v_q[NSTG];
   assign o_result = x_q[NSTG];
   assign o_cout   = c_q[NSTG];
   assign o_ovf    = ovf_q;
   assign o_zero   = zero_q;
   assign o_neg    = neg_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: a 32/8 instance driven by a vector table and
// hand-written stall/reset sequences, and a 16/4 instance driven randomly.
// Expected beats are queued on acceptance and compared on consumption.
module tb_cla_pipe_addsub;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic clr;

   logic        v32_in, rdy32_out, sub32, cin32, vo32, rdy32_in, cout32, ovf32, zero32, neg32;
   logic [31:0] a32, b32, res32;
   logic        v16_in, rdy16_out, sub16, cin16, vo16, rdy16_in, cout16, ovf16, zero16, neg16;
   logic [15:0] a16, b16, res16;

   cla_pipe_addsub #(.WIDTH(32), .SEG_W(8)) u_dut32 (
      .clk(clk), .clr(clr), .i_valid(v32_in), .o_ready(rdy32_out), .i_a(a32), .i_b(b32),
      .i_sub(sub32), .i_cin(cin32), .o_valid(vo32), .i_ready(rdy32_in), .o_result(res32),
      .o_cout(cout32), .o_ovf(ovf32), .o_zero(zero32), .o_neg(neg32));

   cla_pipe_addsub #(.WIDTH(16), .SEG_W(4)) u_dut16 (
      .clk(clk), .clr(clr), .i_valid(v16_in), .o_ready(rdy16_out), .i_a(a16), .i_b(b16),
      .i_sub(sub16), .i_cin(cin16), .o_valid(vo16), .i_ready(rdy16_in), .o_result(res16),
      .o_cout(cout16), .o_ovf(ovf16), .o_zero(zero16), .o_neg(neg16));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        cin;
      logic [31:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } vec_t;

   localparam int NV = 10;
   vec_t tbl [NV];

   int n_checks = 0;
   int n_fail   = 0;

   logic [35:0] q32 [$];
   logic [19:0] q16 [$];
   logic [35:0] exp32_next;
   logic [19:0] exp16_next;
   int run32 = 0, max_run32 = 0, n_cons32 = 0;
   int n_acc16 = 0, n_cons16 = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain wide addition, overflow from operand/result signs.
   function automatic logic [35:0] model32(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic cin);
      logic [31:0] bb;
      logic [32:0] full;
      logic        ov;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
      ov   = (a[31] == bb[31]) && (full[31] != a[31]);
      return {full[31:0], full[32], ov, (full[31:0] == 32'd0), full[31]};
   endfunction

   function automatic logic [19:0] model16(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub, input logic cin);
      logic [15:0] bb;
      logic [16:0] full;
      logic        ov;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
      ov   = (a[15] == bb[15]) && (full[15] != a[15]);
      return {full[15:0], full[16], ov, (full[15:0] == 16'd0), full[15]};
   endfunction

   // Scoreboard for the 32-bit instance.
   initial begin
      logic [35:0] e;
      forever begin
         @(negedge clk);
         if (!clr) begin
            if (vo32 && rdy32_in) begin
               n_cons32++;
               chk("sb32_has_expect", 64'(q32.size() != 0), 64'd1);
               if (q32.size() != 0) begin
                  e = q32.pop_front();
                  chk("sb32_beat", {res32, cout32, ovf32, zero32, neg32}, e);
               end
            end
            if (v32_in && rdy32_out) q32.push_back(exp32_next);
            run32 = vo32 ? run32 + 1 : 0;
            if (run32 > max_run32) max_run32 = run32;
         end
      end
   end

   // Scoreboard for the 16-bit instance.
   initial begin
      logic [19:0] e;
      forever begin
         @(negedge clk);
         if (!clr) begin
            if (vo16 && rdy16_in) begin
               n_cons16++;
               chk("sb16_has_expect", 64'(q16.size() != 0), 64'd1);
               if (q16.size() != 0) begin
                  e = q16.pop_front();
                  chk("sb16_beat", {res16, cout16, ovf16, zero16, neg16}, e);
               end
            end
            if (v16_in && rdy16_out) begin
               q16.push_back(exp16_next);
               n_acc16++;
            end
         end
      end
   end

   // Present one beat and hold it until the DUT accepts it.
   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic cin, input logic [35:0] exp);
      logic acc;
      int   t;
      a32 = a; b32 = b; sub32 = sub; cin32 = cin; exp32_next = exp; v32_in = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 50) begin
         @(negedge clk);
         acc = rdy32_out;
         @(posedge clk);
         #1;
         t++;
      end
      chk("send32_accepted", 64'(acc), 64'd1);
   endtask

   task automatic send32_rand();
      logic [31:0] a, b;
      logic        s, c;
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
      send32(a, b, s, c, model32(a, b, s, c));
   endtask

   task automatic drain32(input string name);
      int t;
      t = 0;
      while (q32.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(name, 64'(q32.size()), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, c0, nv, t;
      logic [31:0] held;

      tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{32'h000000FF, 32'h000000FF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};

      clr = 1'b1;
      v32_in = 1'b0; a32 = 32'd0; b32 = 32'd0; sub32 = 1'b0; cin32 = 1'b0; rdy32_in = 1'b1;
      v16_in = 1'b0; a16 = 16'd0; b16 = 16'd0; sub16 = 1'b0; cin16 = 1'b0; rdy16_in = 1'b1;
      exp32_next = 36'd0; exp16_next = 20'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_o_valid32", 64'(vo32), 64'd0);
      chk("reset_o_ready32", 64'(rdy32_out), 64'd1);
      chk("reset_outputs32", {res32, cout32, ovf32, zero32, neg32}, 64'd0);
      chk("reset_outputs16", {vo16, res16, cout16, ovf16, zero16, neg16}, 64'd0);
      @(negedge clk);
      clr = 1'b0;
      @(posedge clk);
      #1;

      // Latency of a lone beat.
      a32 = tbl[0].a; b32 = tbl[0].b; sub32 = tbl[0].sub; cin32 = tbl[0].cin;
      exp32_next = {tbl[0].res, tbl[0].cout, tbl[0].ovf, tbl[0].zero, tbl[0].neg};
      v32_in = 1'b1;
      @(posedge clk);
      #1;
      v32_in = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!vo32 && lat < 20);
      chk("latency_cycles", 64'(lat), 64'd4);
      drain32("drain_latency");

      // Vector table back-to-back with the sink always ready.
      repeat (3) @(posedge clk);
      #1;
      max_run32 = 0;
      for (int i = 0; i < NV; i++) begin
         send32(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin,
                {tbl[i].res, tbl[i].cout, tbl[i].ovf, tbl[i].zero, tbl[i].neg});
      end
      v32_in = 1'b0;
      drain32("drain_table");
      chk("b2b_valid_run", 64'(max_run32), 64'(NV));

      // Fill the pipe with the sink stalled, hold, then release while sending.
      repeat (2) @(posedge clk);
      #1;
      c0 = n_cons32;
      rdy32_in = 1'b0;
      for (int i = 0; i < 5; i++) send32_rand();
      v32_in = 1'b0;
      chk("stall_o_valid", 64'(vo32), 64'd1);
      held = res32;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("stall_o_ready", 64'(rdy32_out), 64'd0);
         chk("stall_result_held", 64'(res32), 64'(held));
      end
      rdy32_in = 1'b1;
      for (int i = 0; i < 3; i++) send32_rand();
      v32_in = 1'b0;
      drain32("drain_stall");
      chk("stall_beats_delivered", 64'(n_cons32 - c0), 64'd8);

      // Reset mid-stream: one beat at the output, three behind it.
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send32_rand();
      v32_in = 1'b0;
      @(posedge clk);
      #2;
      chk("pre_clr_o_valid", 64'(vo32), 64'd1);
      clr = 1'b1;
      #1;
      chk("clr_o_valid", 64'(vo32), 64'd0);
      chk("clr_o_ready", 64'(rdy32_out), 64'd1);
      chk("clr_result", 64'(res32), 64'd0);
      q32.delete();
      @(negedge clk);
      clr = 1'b0;
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (vo32) nv++;
      end
      chk("no_stale_after_clr", 64'(nv), 64'd0);

      // 16-bit instance: random operands, valid and ready.
      t = 0;
      while (n_acc16 < 10000 && t < 60000) begin
         @(posedge clk);
         #1;
         a16 = 16'($urandom); b16 = 16'($urandom);
         sub16 = 1'($urandom_range(0, 1)); cin16 = 1'($urandom_range(0, 1));
         v16_in = ($urandom_range(0, 3) != 0);
         rdy16_in = ($urandom_range(0, 3) != 0);
         exp16_next = model16(a16, b16, sub16, cin16);
         t++;
      end
      @(posedge clk);
      #1;
      v16_in = 1'b0;
      rdy16_in = 1'b1;
      t = 0;
      while (q16.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk("rand16_enough_beats", 64'(n_acc16 >= 10000), 64'd1);
      chk("rand16_drained", 64'(q16.size()), 64'd0);
      chk("rand16_all_delivered", 64'(n_cons16), 64'(n_acc16));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
